// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Tracks destination registers of in-flight long-latency operations
//   (FP div/sqrt, load miss) and stalls the ID stage on RAW/WAW hazards
//   against them or when too many long-latency ops are outstanding.
//   Also arbitrates the single writeback port between the normal pipeline
//   and the long-latency unit, with a small starvation counter that
//   periodically forces the port over to the long-latency unit.
//
// Build option:
//   FP_SCOREBOARD_EN  - when defined, a separate FP busy bitmap is kept and
//                       FP sources/destinations are hazard-checked. When
//                       undefined, FP registers are never considered busy and
//                       FP retires only update the outstanding count.
//
// Parameters:
//   MAX_OUTSTANDING   - limit on in-flight long-latency ops (1..3).
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ID_valid                      instruction present in ID
//   ID_rs1/ID_rs2/ID_rs3          source register indices
//   ID_use[2:0]                   bit i = source i+1 is read
//   ID_src_fp[2:0]                bit i = source i+1 is an FP register
//   ID_rd, ID_wr_en, ID_rd_fp     destination index / write enable / FP dest
//   ID_multicycle                 instruction goes to the long-latency unit
//   WB_pipe_wr_en                 pipeline wants the writeback port
//   LU_done_valid/_rd/_fp         long-latency result handshake and target
//   ID_stall                      hold ID/EX, bubble into EX
//   LU_done_ready                 long-latency result accepted this cycle
//   WB_sel                        writeback owner (1 = long-latency unit)
//   EX_hold                       freeze EX->WB for one cycle
//   outstanding                   long-latency ops in flight
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ID_valid,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic [4:0] ID_rs3,
    input  logic [2:0] ID_use,
    input  logic [2:0] ID_src_fp,
    input  logic [4:0] ID_rd,
    input  logic       ID_wr_en,
    input  logic       ID_rd_fp,
    input  logic       ID_multicycle,
    input  logic       WB_pipe_wr_en,
    input  logic       LU_done_valid,
    input  logic [4:0] LU_done_rd,
    input  logic       LU_done_fp,
    output logic       ID_stall,
    output logic       LU_done_ready,
    output logic       WB_sel,
    output logic       EX_hold,
    output logic [1:0] outstanding
);

    localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

    logic [31:0] r_int_busy;
    logic [31:0] w_int_busy_nxt;
    logic [31:0] w_fp_busy;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_starve_cnt;

    logic [4:0]  w_rs [3];
    logic        w_raw;
    logic        w_waw;
    logic        w_limit;
    logic        w_starve_grant;
    logic        w_issue;
    logic        w_retire;
    logic        w_retire_eff;

    // Busy lookup into whichever bitmap the operand belongs to.
    function automatic logic busy_lookup(input logic        fp,
                                         input logic [4:0]  idx,
                                         input logic [31:0] int_map,
                                         input logic [31:0] fp_map);
        return fp ? fp_map[idx] : int_map[idx];
    endfunction

`ifdef FP_SCOREBOARD_EN
    logic [31:0] r_fp_busy;
    logic [31:0] w_fp_busy_nxt;

    always_comb begin
        w_fp_busy_nxt = r_fp_busy;
        if (w_retire_eff && LU_done_fp)
            w_fp_busy_nxt[LU_done_rd] = 1'b0;
        // Applied after the clear so a same-cycle issue wins.
        if (w_issue && ID_rd_fp)
            w_fp_busy_nxt[ID_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_fp_busy <= '0;
        else
            r_fp_busy <= w_fp_busy_nxt;
    end

    assign w_fp_busy = r_fp_busy;
`else
    // FP registers are never tracked in this build.
    assign w_fp_busy = '0;
`endif

    assign w_rs[0] = ID_rs1;
    assign w_rs[1] = ID_rs2;
    assign w_rs[2] = ID_rs3;

    // Hazards look only at registered bitmaps, so a retire in this cycle
    // releases a dependent instruction one cycle later.
    always_comb begin
        w_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ID_use[i] && busy_lookup(ID_src_fp[i], w_rs[i], r_int_busy, w_fp_busy))
                w_raw = 1'b1;
        end
    end

    assign w_waw   = ID_wr_en && busy_lookup(ID_rd_fp, ID_rd, r_int_busy, w_fp_busy);
    assign w_limit = ID_multicycle && (r_outstanding == MAX_OUT);

    assign ID_stall = rst_n && ID_valid && (w_raw || w_waw || w_limit);

    // Counter at 3 means three straight cycles of a blocked result: hand the
    // port to the long-latency unit and freeze EX for this one cycle.
    assign w_starve_grant = (r_starve_cnt == 2'd3);

    assign LU_done_ready = rst_n && LU_done_valid && (!WB_pipe_wr_en || w_starve_grant);
    assign WB_sel        = LU_done_ready;
    assign EX_hold       = rst_n && w_starve_grant;

    assign w_issue  = ID_valid && !ID_stall && ID_multicycle && ID_wr_en;
    assign w_retire = LU_done_valid && LU_done_ready;
    // A retire with nothing in flight is a leftover from before a reset.
    assign w_retire_eff = w_retire && (r_outstanding != 2'd0);

    always_comb begin
        w_int_busy_nxt = r_int_busy;
        if (w_retire_eff && !LU_done_fp)
            w_int_busy_nxt[LU_done_rd] = 1'b0;
        // Applied after the clear so a same-cycle issue wins.
        if (w_issue && !ID_rd_fp)
            w_int_busy_nxt[ID_rd] = 1'b1;
        // x0 is hardwired zero and can never be a hazard.
        w_int_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_int_busy    <= '0;
            r_outstanding <= '0;
            r_starve_cnt  <= '0;
        end else begin
            r_int_busy <= w_int_busy_nxt;

            case ({w_issue, w_retire_eff})
                2'b10:   r_outstanding <= r_outstanding + 2'd1;
                2'b01:   r_outstanding <= r_outstanding - 2'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (!LU_done_valid || w_retire)
                r_starve_cnt <= 2'd0;
            else if (r_starve_cnt != 2'd3)
                r_starve_cnt <= r_starve_cnt + 2'd1;
        end
    end

    assign outstanding = r_outstanding;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning):
 clk  input  1  single clock, rising edge
 rst_n  input  1  reset, synchronous, active-low
 ID_valid  input  1  instruction present in ID
 ID_rs1 / ID_rs2 / ID_rs3  input  5 each  source register indices
 ID_use  input  3  bit i = source i+1 is read
 ID_src_fp  input  3  bit i = source i+1 is an FP register
 ID_rd  input  5  destination index
 ID_wr_en  input  1  instruction writes ID_rd
 ID_rd_fp  input  1  destination is an FP register
 ID_multicycle  input  1  instruction issues to the long-latency unit (FP div/sqrt, load miss)
 WB_pipe_wr_en  input  1  pipelined op occupies the writeback port this cycle
 LU_done_valid  input  1  long-latency result ready
 LU_done_rd  input  5  result destination
 LU_done_fp  input  1  result targets an FP register
 ID_stall  output  1  hold ID/EX; insert bubble into EX
 LU_done_ready  output  1  long-latency result accepted this cycle
 WB_sel  output  1  0 = pipeline owns writeback port, 1 = long-latency unit
 EX_hold  output  1  freeze EX->WB advance for one cycle (starvation relief)
 outstanding  output  2  multicycle ops in flight
REQ-002 SHALL use: one clock; reset is synchronous and active-low.
REQ-003 SHALL define parameter MAX_OUTSTANDING, default 2, range 1..3: limit on in-flight multicycle ops.

Function
REQ-004 SHALL keep busy bitmaps int_busy[31:0] and fp_busy[31:0]; int_busy[0] SHALL always read 0.
REQ-005 SHALL define issue = ID_valid && !ID_stall && ID_multicycle && ID_wr_en; on issue, busy bit of ID_rd in the bitmap selected by ID_rd_fp SHALL be set at the next edge.
REQ-006 SHALL define retire = LU_done_valid && LU_done_ready; on retire, busy bit of LU_done_rd in the bitmap selected by LU_done_fp SHALL clear at the next edge.
REQ-007 If issue and retire target the same bit in the same cycle, set SHALL win.
REQ-008 ID_stall SHALL be combinational, asserted when ID_valid and any of: a used source is busy in its bitmap (RAW); ID_wr_en and ID_rd busy (WAW); ID_multicycle and outstanding == MAX_OUTSTANDING.
REQ-009 Busy state SHALL be evaluated on registered bitmaps only; a same-cycle retire SHALL NOT release a stall (release one cycle later).
REQ-010 outstanding SHALL increment on issue, decrement on retire, hold on both; SHALL never exceed MAX_OUTSTANDING nor go below 0.
REQ-011 LU_done_ready SHALL equal LU_done_valid && (!WB_pipe_wr_en || starve_grant); WB_sel SHALL equal LU_done_ready.
REQ-012 SHALL keep 2-bit starvation counter: increments each cycle LU_done_valid && !LU_done_ready; clears on retire or when LU_done_valid is low.
REQ-013 When counter reaches 3, EX_hold SHALL assert for exactly the following cycle and starve_grant SHALL be 1 that cycle, giving the long-latency unit the port; counter then clears.
REQ-014 Retire while outstanding == 0 SHALL be ignored (no bit change, no decrement).

Reset
REQ-015 On rst_n low at a clock edge: int_busy, fp_busy, outstanding, starvation counter, starve_grant SHALL clear to 0; ID_stall, LU_done_ready, WB_sel, EX_hold SHALL read 0 while in reset.
REQ-016 Reset mid-operation SHALL drop all pending busy bits; in-flight results arriving later SHALL be ignored per REQ-014.

Configuration
REQ-017 With FP_SCOREBOARD_EN defined, fp_busy SHALL be implemented per REQ-004..REQ-008.
REQ-018 Without FP_SCOREBOARD_EN, fp_busy SHALL be absent; FP sources, destinations and retires SHALL be treated as never busy and retires SHALL only update outstanding.

Verification
REQ-019 Issue fdiv ID_rd=5 fp; next cycle fadd rs1=f5 -> ID_stall=1 until edge after retire of f5, then 0.
REQ-020 Issue multicycle rd=x0 -> int_busy stays 0, outstanding=1; consumer of x0 never stalls.
REQ-021 Two multicycle issues (MAX=2), third multicycle at ID -> ID_stall=1; one retire -> stall drops next cycle, outstanding 2->1->2.
REQ-022 LU_done_valid held with WB_pipe_wr_en=1 for 3 cycles -> cycle 4 EX_hold=1, LU_done_ready=1, WB_sel=1; counter back to 0.
REQ-023 Retire x7 and issue new multicycle rd=x7 in same cycle -> int_busy[7]=1 afterwards, outstanding unchanged.
REQ-024 rst_n low with outstanding=2 and busy bits set -> all cleared next edge; later LU_done_valid ignored.
